// File: rtl/card_draw_sequencer.sv
// rtl/card_draw_sequencer.sv - card print sequencer: command FIFO, hand slot allocation, write/waitrequest initiator
//
// Accepts clear/deal commands through a valid/ready FIFO. Each card gets the next slot in the
// dealer or player hand. One print request goes out per command and is held until accepted.
//
// Optional feature macro: HOLE_CARD_EN (dealer slot 1 drawn face down, revealed on a reveal pulse).
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   reveal                        (HOLE_CARD_EN only) single-cycle pulse to flip the hole card
//   cmd_valid/cmd_ready           command handshake; cmd_ready = !full
//   cmd_clear/cmd_dealer/cmd_card command fields
//   write/init/card/orig          print request, held stable while waitrequest=1
//   waitrequest                   printer busy
//   busy                          FIFO non-empty or request outstanding
//   dealer_count/player_count     cards placed per hand
//   overflow                      sticky: a card was dropped because its hand was full
module card_draw_sequencer #(
    parameter int DEPTH     = 4,
    parameter int MAX_SLOTS = 12,
    parameter int X_BASE    = 4,
    parameter int X_STEP    = 12,
    parameter int DEALER_Y  = 20,
    parameter int PLAYER_Y  = 80
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef HOLE_CARD_EN
    input  logic        reveal,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_clear,
    input  logic        cmd_dealer,
    input  logic [5:0]  cmd_card,
    output logic        write,
    output logic        init,
    output logic [5:0]  card,
    output logic [14:0] orig,
    input  logic        waitrequest,
    output logic        busy,
    output logic [3:0]  dealer_count,
    output logic [3:0]  player_count,
    output logic        overflow
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [3:0]  MAX_CNT  = 4'(MAX_SLOTS);
    localparam logic [7:0]  XB       = 8'(X_BASE);
    localparam logic [7:0]  XS       = 8'(X_STEP);
    localparam logic [6:0]  DY       = 7'(DEALER_Y);
    localparam logic [6:0]  PY       = 7'(PLAYER_Y);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;
    state_t state_q, state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    logic        write_q, write_d, init_q, init_d;
    logic [5:0]  card_q, card_d;
    logic [14:0] orig_q, orig_d;
    logic [3:0]  dealer_count_q, dealer_count_d, player_count_q, player_count_d;
    logic        overflow_q, overflow_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;

    // Head-of-queue decode
    logic [7:0] head;
    logic       head_clear, head_dealer, fifo_empty, hand_room, start_issue;
    logic [3:0] hand_cnt;
    logic [7:0] slot_x;
    logic [6:0] hand_y;

`ifdef HOLE_CARD_EN
    logic       reveal_pending_q, reveal_pending_d;
    logic       reveal_issue_q, reveal_issue_d;
    logic [5:0] hole_q, hole_d;
`endif

    assign push        = cmd_valid && cmd_ready_q;
    assign head        = mem_q[rd_ptr_q];
    assign head_clear  = head[7];
    assign head_dealer = head[6];
    assign fifo_empty  = (cnt_q == '0);
    assign hand_cnt    = head_dealer ? dealer_count_q : player_count_q;
    assign hand_room   = hand_cnt < MAX_CNT;
    assign slot_x      = XB + 8'(hand_cnt) * XS;
    assign hand_y      = head_dealer ? DY : PY;
`ifdef HOLE_CARD_EN
    assign start_issue = reveal_pending_q || (!fifo_empty && (head_clear || hand_room));
`else
    assign start_issue = !fifo_empty && (head_clear || hand_room);
`endif

    // FIFO storage carries no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_clear, cmd_dealer, cmd_card};
    end

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State register plus all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            write_q        <= 1'b0;
            init_q         <= 1'b0;
            card_q         <= '0;
            orig_q         <= '0;
            dealer_count_q <= '0;
            player_count_q <= '0;
            overflow_q     <= 1'b0;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
`ifdef HOLE_CARD_EN
            reveal_pending_q <= 1'b0;
            reveal_issue_q   <= 1'b0;
            hole_q           <= '0;
`endif
        end else begin
            state_q        <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q          <= cnt_d;
            write_q        <= write_d;
            init_q         <= init_d;
            card_q         <= card_d;
            orig_q         <= orig_d;
            dealer_count_q <= dealer_count_d;
            player_count_q <= player_count_d;
            overflow_q     <= overflow_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
`ifdef HOLE_CARD_EN
            reveal_pending_q <= reveal_pending_d;
            reveal_issue_q   <= reveal_issue_d;
            hole_q           <= hole_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_issue) state_d = S_ISSUE;
            S_ISSUE: if (!waitrequest) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pop            = 1'b0;
        write_d        = write_q;
        init_d         = init_q;
        card_d         = card_q;
        orig_d         = orig_q;
        dealer_count_d = dealer_count_q;
        player_count_d = player_count_q;
        overflow_d     = overflow_q;
`ifdef HOLE_CARD_EN
        reveal_pending_d = reveal_pending_q;
        reveal_issue_d   = reveal_issue_q;
        hole_d           = hole_q;
        if (reveal && dealer_count_q >= 4'd2) reveal_pending_d = 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                write_d = 1'b0;
`ifdef HOLE_CARD_EN
                reveal_issue_d = 1'b0;
                if (reveal_pending_q) begin
                    init_d         = 1'b0;
                    card_d         = hole_q;
                    orig_d         = {XB + XS, DY};
                    write_d        = 1'b1;
                    reveal_issue_d = 1'b1;
                end else
`endif
                if (!fifo_empty) begin
                    if (head_clear) begin
                        init_d  = 1'b1;
                        card_d  = '0;
                        orig_d  = '0;
                        write_d = 1'b1;
                    end else if (hand_room) begin
                        init_d  = 1'b0;
                        card_d  = head[5:0];
                        orig_d  = {slot_x, hand_y};
                        write_d = 1'b1;
`ifdef HOLE_CARD_EN
                        // Second dealer card goes out face down; keep the real one
                        if (head_dealer && dealer_count_q == 4'd1) begin
                            card_d = {4'd14, head[1:0]};
                            hole_d = head[5:0];
                        end
`endif
                    end else begin
                        pop        = 1'b1;
                        overflow_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!waitrequest) begin
                    write_d = 1'b0;
`ifdef HOLE_CARD_EN
                    if (reveal_issue_q) reveal_pending_d = 1'b0;
                    else
`endif
                    begin
                        pop = 1'b1;
                        if (head_clear) begin
                            dealer_count_d = '0;
                            player_count_d = '0;
                            overflow_d     = 1'b0;
`ifdef HOLE_CARD_EN
                            reveal_pending_d = 1'b0;
`endif
                        end else if (head_dealer) begin
                            dealer_count_d = dealer_count_q + 4'd1;
                        end else begin
                            player_count_d = player_count_q + 4'd1;
                        end
                    end
                end
            end
            default: write_d = 1'b0;
        endcase
    end

    assign cmd_ready_d = (cnt_d != FULL_CNT);
    assign busy_d      = (cnt_d != '0) || write_d;

    assign write        = write_q;
    assign init         = init_q;
    assign card         = card_q;
    assign orig         = orig_q;
    assign dealer_count = dealer_count_q;
    assign player_count = player_count_q;
    assign overflow     = overflow_q;
    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_card_draw_sequencer.sv
// tb/tb_card_draw_sequencer.sv - self-checking bench for card_draw_sequencer
module tb_card_draw_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_ready, cmd_clear, cmd_dealer;
    logic [5:0]  cmd_card;
    logic        write, init, waitrequest, busy, overflow;
    logic [5:0]  card;
    logic [14:0] orig;
    logic [3:0]  dealer_count, player_count;
`ifdef HOLE_CARD_EN
    logic        reveal = 1'b0;
`endif

    always #5 clk = ~clk;

    card_draw_sequencer dut (
`ifdef HOLE_CARD_EN
        .reveal(reveal),
`endif
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_clear(cmd_clear), .cmd_dealer(cmd_dealer), .cmd_card(cmd_card),
        .write(write), .init(init), .card(card), .orig(orig),
        .waitrequest(waitrequest), .busy(busy),
        .dealer_count(dealer_count), .player_count(player_count), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    bit wr_rand = 1'b0;

    typedef struct {
        logic        init;
        logic [5:0]  card;
        logic [14:0] orig;
    } xfer_t;
    xfer_t exp_q[$];
    xfer_t mon_e;

    typedef struct {
        logic        clear;
        logic        dealer;
        logic [5:0]  card;
        logic        xfer;
        logic        e_init;
        logic [5:0]  e_card;
        logic [14:0] e_orig;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transfer monitor: a transfer completes at the next edge when write=1 and waitrequest=0
    always @(negedge clk) begin
        if (rst_n === 1'b1 && write === 1'b1 && waitrequest === 1'b0) begin
            xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got card %0h orig %0h init %0b, expected none", card, orig, init);
            end else begin
                mon_e = exp_q.pop_front();
                check("xfer_init", 32'(init), 32'(mon_e.init));
                check("xfer_card", 32'(card), 32'(mon_e.card));
                check("xfer_orig", 32'(orig), 32'(mon_e.orig));
            end
        end
    end

    always @(posedge clk) begin
        if (wr_rand) begin
            #1;
            waitrequest = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic i, input logic [5:0] c, input logic [14:0] o);
        xfer_t e;
        e.init = i; e.card = c; e.orig = o;
        exp_q.push_back(e);
    endtask

    task automatic push_cmd(input logic c, input logic d, input logic [5:0] k);
        int n = 0;
        cmd_valid = 1'b1; cmd_clear = c; cmd_dealer = d; cmd_card = k;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: cmd_ready %0b, expected 1", cmd_ready);
        end else begin
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy %0b, expected 0", busy);
        end
        tick();
    endtask

    initial begin
        int bad;
        int snap;

        vecs[0] = '{1'b0, 1'b0, 6'b001110, 1'b1, 1'b0, 6'b001110, {8'd4,  7'd80}};
        vecs[1] = '{1'b0, 1'b0, 6'b110011, 1'b1, 1'b0, 6'b110011, {8'd16, 7'd80}};
        vecs[2] = '{1'b0, 1'b1, 6'b000101, 1'b1, 1'b0, 6'b000101, {8'd4,  7'd20}};
        vecs[3] = '{1'b1, 1'b0, 6'b101010, 1'b1, 1'b1, 6'b000000, 15'd0};
        vecs[4] = '{1'b0, 1'b1, 6'b111111, 1'b1, 1'b0, 6'b111111, {8'd4,  7'd20}};
        vecs[5] = '{1'b0, 1'b0, 6'b000010, 1'b1, 1'b0, 6'b000010, {8'd4,  7'd80}};
        vecs[6] = '{1'b0, 1'b0, 6'b011000, 1'b1, 1'b0, 6'b011000, {8'd16, 7'd80}};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_dealer = 1'b0;
        cmd_card = '0; waitrequest = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_write", 32'(write), 0);
        check("rst_init", 32'(init), 0);
        check("rst_card", 32'(card), 0);
        check("rst_orig", 32'(orig), 0);
        check("rst_counts", 32'({dealer_count, player_count}), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cmd_ready), 1);

        // Clear held under waitrequest, then a single transfer
        expect_xfer(1'b1, 6'd0, 15'd0);
        push_cmd(1'b1, 1'b0, 6'b010101);
        check("latency_n1_write", 32'(write), 0);
        tick();
        check("latency_n2_write", 32'(write), 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!(write && init && card == 6'd0 && orig == 15'd0 && busy)) bad++;
            tick();
        end
        check("clear_hold_50", 32'(bad), 0);
        waitrequest = 1'b0;
        tick();
        waitrequest = 1'b1;
        check("clear_write_drop", 32'(write), 0);
        tick();
        check("clear_single_xfer", 32'(xfers), 1);
        check("clear_counts", 32'({dealer_count, player_count}), 0);

        // Player then dealer card
        waitrequest = 1'b0;
        expect_xfer(1'b0, 6'b001110, {8'd4, 7'd80});
        expect_xfer(1'b0, 6'b000101, {8'd4, 7'd20});
        push_cmd(1'b0, 1'b0, 6'b001110);
        push_cmd(1'b0, 1'b1, 6'b000101);
        wait_idle();
        check("pd_player_count", 32'(player_count), 1);
        check("pd_dealer_count", 32'(dealer_count), 1);

        // 13 player cards after a clear: 13th overflows
        expect_xfer(1'b1, 6'd0, 15'd0);
        push_cmd(1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 13; i++) begin
            if (i < 12) expect_xfer(1'b0, {4'(i), 2'b01}, {8'(4 + 12 * i), 7'd80});
            push_cmd(1'b0, 1'b0, {4'(i), 2'b01});
        end
        wait_idle();
        check("full_player_count", 32'(player_count), 12);
        check("full_overflow", 32'(overflow), 1);
        check("full_drained", 32'(exp_q.size()), 0);
        expect_xfer(1'b1, 6'd0, 15'd0);
        push_cmd(1'b1, 1'b0, 6'd0);
        wait_idle();
        check("clear_overflow", 32'(overflow), 0);
        check("clear_player_count", 32'(player_count), 0);

        // Fill the FIFO while the printer stalls
        waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_dealer = 1'b0;
            cmd_card = {4'(i + 3), 2'b10};
            expect_xfer(1'b0, {4'(i + 3), 2'b10}, {8'(4 + 12 * i), 7'd80});
            check("fill_ready_before", 32'(cmd_ready), 1);
            tick();
        end
        check("fill_ready_full", 32'(cmd_ready), 0);
        cmd_card = 6'b111111;
        repeat (3) tick();
        check("fill_ready_still", 32'(cmd_ready), 0);
        cmd_valid = 1'b0;
        waitrequest = 1'b0;
        wait_idle();
        check("fill_drained", 32'(exp_q.size()), 0);
        check("fill_player_count", 32'(player_count), 4);

        // Reset during ISSUE discards everything
        waitrequest = 1'b1;
        push_cmd(1'b0, 1'b1, 6'b000111);
        push_cmd(1'b0, 1'b0, 6'b001011);
        check("issue_pre_write", 32'(write), 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_write", 32'(write), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        check("mid_rst_counts", 32'({dealer_count, player_count}), 0);
        rst_n = 1'b1;
        snap = xfers;
        waitrequest = 1'b0;
        repeat (6) tick();
        check("mid_rst_no_xfer", 32'(xfers - snap), 0);

        // Table-driven vectors under random printer stalls
        wr_rand = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].xfer) expect_xfer(vecs[i].e_init, vecs[i].e_card, vecs[i].e_orig);
            push_cmd(vecs[i].clear, vecs[i].dealer, vecs[i].card);
        end
        wait_idle();
        wr_rand = 1'b0;
        tick();
        waitrequest = 1'b0;
        wait_idle();
        check("tbl_drained", 32'(exp_q.size()), 0);
        check("tbl_player_count", 32'(player_count), 2);
        check("tbl_dealer_count", 32'(dealer_count), 1);

`ifdef HOLE_CARD_EN
        expect_xfer(1'b1, 6'd0, 15'd0);
        push_cmd(1'b1, 1'b0, 6'd0);
        expect_xfer(1'b0, 6'b000011, {8'd4, 7'd20});
        push_cmd(1'b0, 1'b1, 6'b000011);
        wait_idle();
        snap = xfers;
        reveal = 1'b1; tick(); reveal = 1'b0;
        repeat (4) tick();
        check("hole_early_reveal_ignored", 32'(xfers - snap), 0);
        expect_xfer(1'b0, 6'b111001, {8'd16, 7'd20});
        push_cmd(1'b0, 1'b1, 6'b100001);
        wait_idle();
        expect_xfer(1'b0, 6'b100001, {8'd16, 7'd20});
        reveal = 1'b1; tick(); reveal = 1'b0;
        repeat (3) tick();
        wait_idle();
        check("hole_drained", 32'(exp_q.size()), 0);
        check("hole_dealer_count", 32'(dealer_count), 2);
`endif

        check("final_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
